// File: rtl/merge2_stage.sv
// merge2_stage: two-way merge of sorted runs for the merge-sort datapath.
// Pulls one sorted run of RUN words from each of two upstream FIFOs and writes
// a single sorted run of 2*RUN words into the downstream FIFO.
//
// Handshake: a FIFO word moves when its rd_en is high at a rising clk edge.
// rd_en is combinational and is never raised while that FIFO reports empty,
// while out_stall is high, or while reset is high. Each pop produces exactly
// one registered write (out_wr/out_data) on the next cycle. Downstream raises
// out_stall while it still has one free entry, because that registered write
// is already in flight.
module merge2_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int LOG2_RUN   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] a_dcmp,
    input  logic                  a_empty,
    output logic                  a_rd_en,
    input  logic [DATA_WIDTH-1:0] b_dcmp,
    input  logic                  b_empty,
    output logic                  b_rd_en,
    input  logic                  out_stall,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_wr,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = LOG2_RUN + 1;
    localparam logic [CW-1:0] RUN = CW'(1) << LOG2_RUN;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MERGE   = 2'd1,
        DRAIN_A = 2'd2,
        DRAIN_B = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt_a;
    logic [CW-1:0] cnt_b;
    logic [CW-1:0] cnt_a_nxt;
    logic [CW-1:0] cnt_b_nxt;
    logic          a_fin;
    logic          b_fin;
    logic          a_fin_nxt;
    logic          b_fin_nxt;
    logic          take_a;
    logic          pop;

    assign a_fin     = (cnt_a == RUN);
    assign b_fin     = (cnt_b == RUN);
    // Ties go to A so equal keys keep their A-before-B order.
    assign take_a    = (a_dcmp <= b_dcmp);
    assign pop       = a_rd_en | b_rd_en;
    assign cnt_a_nxt = cnt_a + CW'(a_rd_en);
    assign cnt_b_nxt = cnt_b + CW'(b_rd_en);
    assign a_fin_nxt = (cnt_a_nxt == RUN);
    assign b_fin_nxt = (cnt_b_nxt == RUN);

    // Pop selection: at most one side per cycle, never during reset or stall.
    always_comb begin
        a_rd_en = 1'b0;
        b_rd_en = 1'b0;
        if (!reset) begin
            case (state)
                MERGE: begin
                    // Both heads must be present, otherwise ordering is unknown.
                    if (!a_empty && !b_empty && !out_stall) begin
                        if (take_a) a_rd_en = 1'b1;
                        else        b_rd_en = 1'b1;
                    end
                end
                DRAIN_A: a_rd_en = !a_empty && !out_stall && !a_fin;
                DRAIN_B: b_rd_en = !b_empty && !out_stall && !b_fin;
                default: ;
            endcase
        end
    end

    // Merge FSM, pop counters and the registered write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt_a    <= '0;
            cnt_b    <= '0;
            out_data <= '0;
            out_wr   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            out_wr <= pop;
            done   <= 1'b0;
            if (pop) out_data <= a_rd_en ? a_dcmp : b_dcmp;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= MERGE;
                        cnt_a <= '0;
                        cnt_b <= '0;
                        busy  <= 1'b1;
                    end
                end
                default: begin
                    cnt_a <= cnt_a_nxt;
                    cnt_b <= cnt_b_nxt;
                    if (pop && a_fin_nxt && b_fin_nxt) begin
                        // Last word popped; its write carries done next cycle.
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (state == MERGE && a_fin_nxt) begin
                        state <= DRAIN_B;
                    end else if (state == MERGE && b_fin_nxt) begin
                        state <= DRAIN_A;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_merge2_stage.sv
// Bench for merge2_stage with RUN = 4: upstream FIFOs are modelled as queues,
// downstream writes are collected and compared against hand-computed runs.
module tb_merge2_stage;

    localparam int DW = 32;

    logic          clk;
    logic          reset;
    logic          start;
    logic [DW-1:0] a_dcmp;
    logic          a_empty;
    logic          a_rd_en;
    logic [DW-1:0] b_dcmp;
    logic          b_empty;
    logic          b_rd_en;
    logic          out_stall;
    logic [DW-1:0] out_data;
    logic          out_wr;
    logic          busy;
    logic          done;

    merge2_stage #(.DATA_WIDTH(DW), .LOG2_RUN(2)) dut (
        .clk(clk), .reset(reset), .start(start),
        .a_dcmp(a_dcmp), .a_empty(a_empty), .a_rd_en(a_rd_en),
        .b_dcmp(b_dcmp), .b_empty(b_empty), .b_rd_en(b_rd_en),
        .out_stall(out_stall), .out_data(out_data), .out_wr(out_wr),
        .busy(busy), .done(done)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0][DW-1:0] a;
        logic [3:0][DW-1:0] b;
        logic [7:0][DW-1:0] e;
        logic [7:0]         pop_a;  // bit i set: i-th pop taken from A
    } vec_t;

    logic [DW-1:0] a_q[$];
    logic [DW-1:0] b_q[$];
    logic [DW-1:0] got_q[$];
    bit            pop_q[$];
    logic          hold_a, hold_b;
    logic          mid_rd_a, mid_rd_b, mid_wr;
    int            cyc, first_wr, last_wr, done_cnt, done_bad, underflow, both_rd;
    int            checks, errors;

    function automatic logic [3:0][DW-1:0] q4(input logic [DW-1:0] x0, x1, x2, x3);
        q4 = {x3, x2, x1, x0};
    endfunction

    function automatic logic [7:0][DW-1:0] q8(input logic [DW-1:0] x0, x1, x2, x3,
                                              input logic [DW-1:0] x4, x5, x6, x7);
        q8 = {x7, x6, x5, x4, x3, x2, x1, x0};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // One clock: present FIFO heads, sample mid-cycle, then apply pops and log writes.
    task automatic cycle();
        a_empty = hold_a || (a_q.size() == 0);
        b_empty = hold_b || (b_q.size() == 0);
        a_dcmp  = (a_q.size() != 0) ? a_q[0] : '0;
        b_dcmp  = (b_q.size() != 0) ? b_q[0] : '0;
        #3;
        mid_rd_a = a_rd_en;
        mid_rd_b = b_rd_en;
        mid_wr   = out_wr;
        @(posedge clk);
        #1;
        cyc++;
        if (mid_rd_a && mid_rd_b) both_rd++;
        if (mid_rd_a) begin
            if (a_q.size() == 0) underflow++;
            else void'(a_q.pop_front());
            pop_q.push_back(1'b1);
        end
        if (mid_rd_b) begin
            if (b_q.size() == 0) underflow++;
            else void'(b_q.pop_front());
            pop_q.push_back(1'b0);
        end
        if (out_wr) begin
            if (got_q.size() == 0) first_wr = cyc;
            last_wr = cyc;
            got_q.push_back(out_data);
        end
        if (done) begin
            done_cnt++;
            if (!out_wr || got_q.size() != 8 || busy) done_bad++;
        end
    endtask

    task automatic load(input vec_t v);
        a_q.delete();
        b_q.delete();
        for (int i = 0; i < 4; i++) begin
            a_q.push_back(v.a[i]);
            b_q.push_back(v.b[i]);
        end
    endtask

    task automatic start_merge(input string tag);
        got_q.delete();
        pop_q.delete();
        first_wr = 0; last_wr = 0; done_cnt = 0; done_bad = 0;
        underflow = 0; both_rd = 0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        check({tag, "_busy_after_start"}, 64'(busy), 64'd1);
    endtask

    task automatic run_to_done(input string tag);
        int n;
        n = 0;
        while (done_cnt == 0 && n < 40) begin
            cycle();
            n++;
        end
        check({tag, "_done_seen"}, 64'(done_cnt), 64'd1);
        cycle();
        check({tag, "_idle_busy"}, 64'(busy), 64'd0);
        check({tag, "_idle_wr"}, 64'(out_wr), 64'd0);
    endtask

    task automatic check_result(input string tag, input vec_t v, input int exp_gaps, input bit chk_pops);
        logic [7:0] m;
        check({tag, "_nwrites"}, 64'(got_q.size()), 64'd8);
        for (int i = 0; i < 8; i++)
            check($sformatf("%s_word%0d", tag, i),
                  (i < got_q.size()) ? 64'(got_q[i]) : 64'hdead_0000_0000_0000, 64'(v.e[i]));
        if (got_q.size() != 0)
            check({tag, "_gaps"}, 64'(last_wr - first_wr + 1 - got_q.size()), 64'(exp_gaps));
        check({tag, "_done_timing"}, 64'(done_bad), 64'd0);
        check({tag, "_underflow"}, 64'(underflow), 64'd0);
        check({tag, "_dual_pop"}, 64'(both_rd), 64'd0);
        if (chk_pops) begin
            m = '0;
            for (int i = 0; i < 8 && i < pop_q.size(); i++) m[i] = pop_q[i];
            check({tag, "_pop_order"}, 64'(m), 64'(v.pop_a));
        end
    endtask

    vec_t vecs[5];

    initial begin
        checks = 0; errors = 0; cyc = 0;
        reset = 1'b1; start = 1'b0; out_stall = 1'b0;
        hold_a = 1'b0; hold_b = 1'b0;
        a_q.delete(); b_q.delete();

        vecs[0].a = q4(1, 3, 5, 7);        vecs[0].b = q4(2, 4, 6, 8);
        vecs[0].e = q8(1, 2, 3, 4, 5, 6, 7, 8);          vecs[0].pop_a = 8'b0101_0101;
        vecs[1].a = q4(5, 5, 5, 5);        vecs[1].b = q4(5, 5, 5, 5);
        vecs[1].e = q8(5, 5, 5, 5, 5, 5, 5, 5);          vecs[1].pop_a = 8'b0000_1111;
        vecs[2].a = q4(1, 2, 3, 4);        vecs[2].b = q4(10, 20, 30, 40);
        vecs[2].e = q8(1, 2, 3, 4, 10, 20, 30, 40);      vecs[2].pop_a = 8'b0000_1111;
        vecs[3].a = q4(10, 20, 30, 40);    vecs[3].b = q4(1, 2, 3, 4);
        vecs[3].e = q8(1, 2, 3, 4, 10, 20, 30, 40);      vecs[3].pop_a = 8'b1111_0000;
        vecs[4].a = q4(32'h0, 32'h1, 32'h8000_0000, 32'hffff_ffff);
        vecs[4].b = q4(32'h2, 32'h7fff_ffff, 32'h8000_0000, 32'hffff_fffe);
        vecs[4].e = q8(32'h0, 32'h1, 32'h2, 32'h7fff_ffff,
                       32'h8000_0000, 32'h8000_0000, 32'hffff_fffe, 32'hffff_ffff);
        vecs[4].pop_a = 8'b1001_0011;

        // reset state
        cycle();
        cycle();
        reset = 1'b0;
        cycle();
        check("rst_out_wr", 64'(out_wr), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_rd_en", 64'({mid_rd_a, mid_rd_b}), 64'd0);

        // table-driven merges
        for (int k = 0; k < 5; k++) begin
            load(vecs[k]);
            start_merge($sformatf("vec%0d", k));
            run_to_done($sformatf("vec%0d", k));
            check_result($sformatf("vec%0d", k), vecs[k], 0, 1'b1);
        end

        // B runs empty for 3 cycles after two pops
        load(vecs[0]);
        start_merge("bempty");
        cycle();
        cycle();
        hold_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check($sformatf("bempty_rd%0d", i), 64'({mid_rd_a, mid_rd_b}), 64'd0);
            check($sformatf("bempty_wr%0d", i), 64'(out_wr), 64'd0);
        end
        hold_b = 1'b0;
        run_to_done("bempty");
        check_result("bempty", vecs[0], 3, 1'b1);

        // downstream stall for 2 cycles mid-merge
        load(vecs[0]);
        start_merge("stall");
        cycle();
        cycle();
        cycle();
        out_stall = 1'b1;
        cycle();
        check("stall_inflight_wr", 64'(mid_wr), 64'd1);
        check("stall_rd0", 64'({mid_rd_a, mid_rd_b}), 64'd0);
        cycle();
        check("stall_quiet_wr", 64'(mid_wr), 64'd0);
        check("stall_rd1", 64'({mid_rd_a, mid_rd_b}), 64'd0);
        out_stall = 1'b0;
        run_to_done("stall");
        check_result("stall", vecs[0], 2, 1'b1);

        // reset after 3 writes, then a fresh merge with a stray start while busy
        load(vecs[0]);
        start_merge("abort");
        for (int i = 0; i < 20 && got_q.size() < 3; i++) cycle();
        check("abort_pre_writes", 64'(got_q.size()), 64'd3);
        reset = 1'b1;
        cycle();
        check("abort_rd_in_reset", 64'({mid_rd_a, mid_rd_b}), 64'd0);
        check("abort_out_wr", 64'(out_wr), 64'd0);
        check("abort_out_data", 64'(out_data), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        a_q.delete();
        b_q.delete();
        cycle();
        reset = 1'b0;
        cycle();
        load(vecs[2]);
        start_merge("rerun");
        cycle();
        cycle();
        cycle();
        start = 1'b1;
        cycle();
        start = 1'b0;
        run_to_done("rerun");
        check_result("rerun", vecs[2], 0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
